// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART receiver
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;
    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and parallel byte delivery signals of the receiver
interface uart_rx_if;
    import uart_pkg::*;

    logic                 RxD;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_busy;

    modport master (
        input  RxD,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output RxD,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16x oversampling tick divider, held in phase by clear
module uart_baud_tick #(
    parameter int TICK_DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with 16x oversampling and centre sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICK_DIV = 651
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.master  bus
);

    rx_state_t            state, state_n;
    logic                 rxd_meta, rxd_s, rxd_prev;
    logic                 fall;
    logic                 tick;
    logic [3:0]           s_cnt, s_cnt_n;
    logic [2:0]           b_cnt, b_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_r, data_n;
    logic                 valid_r, valid_n;
    logic                 err_r, err_n;

    // Reset to 1 so a line that is idle at release never looks like a START edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= bus.RxD;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    assign fall = rxd_prev && !rxd_s;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            s_cnt   <= '0;
            b_cnt   <= '0;
            shreg   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_n;
            s_cnt   <= s_cnt_n;
            b_cnt   <= b_cnt_n;
            shreg   <= shreg_n;
            data_r  <= data_n;
            valid_r <= valid_n;
            err_r   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        b_cnt_n = b_cnt;
        shreg_n = shreg;
        data_n  = data_r;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == MID_SAMPLE) begin
                        s_cnt_n = '0;
                        b_cnt_n = '0;
                        state_n = rxd_s ? IDLE : DATA;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    s_cnt_n = s_cnt + 4'd1;
                    if (s_cnt == LAST_SAMPLE) begin
                        shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                        if (b_cnt == LAST_BIT) begin
                            state_n = STOP;
                        end else begin
                            b_cnt_n = b_cnt + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    s_cnt_n = s_cnt + 4'd1;
                    if (s_cnt == LAST_SAMPLE) begin
                        state_n = IDLE;
                        if (rxd_s) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_data      = data_r;
    assign bus.rx_valid     = valid_r;
    assign bus.rx_frame_err = err_r;
    assign bus.rx_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed frame tests for uart_rx at TICK_DIV=4
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   wide_cnt = 0;
    int   busy_cyc = 0;
    int   last_valid_cyc = 0;
    int   start_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] got_q[$];

    uart_rx_if bus();

    uart_rx #(.TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                got_q.push_back(bus.rx_data);
            end
            if (bus.rx_frame_err) err_cnt++;
            if (bus.rx_valid && bus.rx_frame_err) both_cnt++;
            if ((bus.rx_valid && prev_valid) || (bus.rx_frame_err && prev_err)) wide_cnt++;
            if (bus.rx_busy) busy_cyc++;
        end
        prev_valid = bus.rx_valid;
        prev_err   = bus.rx_frame_err;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        bus.RxD = b;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        bus.RxD   = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CLK - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int v0, e0, lat;
    logic [7:0] c3;

    initial begin
        bus.RxD = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_data",  bus.rx_data, 8'h00);
        check_eq("reset_valid", bus.rx_valid, 1'b0);
        check_eq("reset_err",   bus.rx_frame_err, 1'b0);
        check_eq("reset_busy",  bus.rx_busy, 1'b0);
        rst = 1'b0;
        idle(2 * BIT_CLK);

        // 1: reset in the middle of 8'hC3, then a clean 8'h5A
        c3 = 8'hC3;
        @(negedge clk);
        bus.RxD = 1'b0;
        repeat (BIT_CLK - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(c3[i]);
        @(negedge clk);
        bus.RxD = c3[4];
        repeat (32) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_busy", bus.rx_busy, 1'b0);
        rst = 1'b0;
        bus.RxD = 1'b1;
        idle(4 * BIT_CLK);
        check_eq("midrst_no_valid", valid_cnt, 0);
        check_eq("midrst_no_err",   err_cnt, 0);
        send_frame(8'h5A, 1'b1);
        idle(BIT_CLK);
        check_eq("t1_valid_cnt", valid_cnt, 1);
        check_eq("t1_data", bus.rx_data, 8'h5A);

        // 2: single frame latency and busy window
        busy_cyc = 0;
        send_frame(8'hA5, 1'b1);
        idle(BIT_CLK);
        lat = last_valid_cyc - start_cyc;
        check_eq("t2_valid_cnt", valid_cnt, 2);
        check_eq("t2_data", bus.rx_data, 8'hA5);
        check_eq("t2_latency_window", (lat >= 606 && lat <= 615), 1'b1);
        check_eq("t2_busy_window", (busy_cyc >= 600 && busy_cyc <= 615), 1'b1);
        check_eq("t2_no_err", err_cnt, 0);
        check_eq("t2_idle_after", bus.rx_busy, 1'b0);

        // 3: back-to-back frames without idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(BIT_CLK);
        check_eq("t3_valid_cnt", valid_cnt, 5);
        check_eq("t3_byte0", got_q[2], 8'h00);
        check_eq("t3_byte1", got_q[3], 8'hFF);
        check_eq("t3_byte2", got_q[4], 8'h55);

        // 4: short low glitch is rejected at the mid-START sample
        v0 = valid_cnt;
        e0 = err_cnt;
        @(negedge clk);
        bus.RxD = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t4_busy_during", bus.rx_busy, 1'b1);
        repeat (6) @(negedge clk);
        bus.RxD = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("t4_busy_after", bus.rx_busy, 1'b0);
        check_eq("t4_no_valid", valid_cnt, v0);
        check_eq("t4_no_err", err_cnt, e0);

        // 5: bad STOP bit leaves rx_data untouched
        send_frame(8'h3C, 1'b0);
        idle(BIT_CLK);
        check_eq("t5_err_cnt", err_cnt, e0 + 1);
        check_eq("t5_no_valid", valid_cnt, v0);
        check_eq("t5_data_held", bus.rx_data, 8'h55);

        // 6: break condition gives one error, then normal reception resumes
        @(negedge clk);
        bus.RxD = 1'b0;
        repeat (3 * 10 * BIT_CLK) @(negedge clk);
        check_eq("t6_idle_in_break", bus.rx_busy, 1'b0);
        idle(2 * BIT_CLK);
        check_eq("t6_err_cnt", err_cnt, e0 + 2);
        check_eq("t6_no_valid", valid_cnt, v0);
        send_frame(8'h81, 1'b1);
        idle(BIT_CLK);
        check_eq("t6_valid_cnt", valid_cnt, v0 + 1);
        check_eq("t6_data", bus.rx_data, 8'h81);

        check_eq("flags_exclusive", both_cnt, 0);
        check_eq("flags_one_clk", wide_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
